// File: rtl/clock_time_setter.sv
// clock_time_setter: pushbutton time-set controller for an HH:MM clock.
//
// Two active-low board keys are synchronized and debounced. A mode press
// walks RUN -> SET_H -> SET_M -> RUN, and an inc press bumps the field
// being edited. Leaving SET_M issues a one-cycle load strobe carrying the
// edited time to the running counters. The field under edit blinks.
//
// Ports:
//   CLOCK_50       in   system clock, rising edge
//   Resetn         in   asynchronous active-low reset
//   KEY_MODE       in   raw mode key, active-low, asynchronous
//   KEY_INC        in   raw increment key, active-low, asynchronous
//   cur_hours      in   live hour count (0-23)
//   cur_minutes    in   live minute count (0-59)
//   running        out  counter enable, high only while not editing
//   load           out  one-cycle load strobe for the counters
//   load_hours     out  hour value to load (always the edit register)
//   load_minutes   out  minute value to load (always the edit register)
//   blank_hours    out  blank hour digits in the current blink phase
//   blank_minutes  out  blank minute digits in the current blink phase
//   state_dbg      out  current FSM state (0 RUN, 1 SET_H, 2 SET_M)
//
// Handshake: there is no valid/ready pair on this block. load is a bare
// one-cycle strobe; the counters must sample load_hours/load_minutes on
// the edge that ends the cycle in which load is high.

// Synchronizer plus debouncer for one active-low key. press is a
// registered one-cycle pulse on each accepted 1->0 change of the
// debounced level; releases produce nothing.
module key_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic         sync1;
  logic         sync2;
  logic         db;
  logic         db_q;
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db    <= 1'b1;
      db_q  <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      db_q  <= db;
      // Edge detect on the delayed copy so the pulse is a clean register.
      press <= db_q & ~db;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt <= '0;
        db  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module clock_time_setter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       running,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic       blank_hours,
  output logic       blank_minutes,
  output logic [1:0] state_dbg
);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  state_t        state;
  logic          mode_p;
  logic          inc_p;
  logic [4:0]    edit_h;
  logic [5:0]    edit_m;
  logic [BW-1:0] bcnt;
  logic          vis;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .key   (KEY_MODE),
    .press (mode_p)
  );

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .key   (KEY_INC),
    .press (inc_p)
  );

  // running is its own register rather than a decode of state: it drops on
  // the same edge that enters SET_H, but rises only one edge after the
  // load strobe, so the counters never run during the load cycle.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state   <= RUN;
      running <= 1'b1;
      load    <= 1'b0;
      edit_h  <= '0;
      edit_m  <= '0;
      bcnt    <= '0;
      vis     <= 1'b1;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          running <= 1'b1;
          bcnt    <= '0;
          vis     <= 1'b1;
          if (mode_p) begin
            edit_h  <= (cur_hours   > 5'd23) ? 5'd0 : cur_hours;
            edit_m  <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
            state   <= SET_H;
            running <= 1'b0;
          end
        end
        SET_H: begin
          if (mode_p) begin
            // Mode has priority; a coincident inc is dropped.
            state <= SET_M;
            bcnt  <= '0;
            vis   <= 1'b1;
          end else if (inc_p) begin
            edit_h <= (edit_h == 5'd23) ? 5'd0 : edit_h + 5'd1;
            bcnt   <= '0;
            vis    <= 1'b1;
          end else if (bcnt == BLAST) begin
            bcnt <= '0;
            vis  <= ~vis;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        SET_M: begin
          if (mode_p) begin
            load  <= 1'b1;
            state <= RUN;
            bcnt  <= '0;
            vis   <= 1'b1;
          end else if (inc_p) begin
            edit_m <= (edit_m == 6'd59) ? 6'd0 : edit_m + 6'd1;
            bcnt   <= '0;
            vis    <= 1'b1;
          end else if (bcnt == BLAST) begin
            bcnt <= '0;
            vis  <= ~vis;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          running <= 1'b1;
          bcnt    <= '0;
          vis     <= 1'b1;
        end
      endcase
    end
  end

  assign load_hours    = edit_h;
  assign load_minutes  = edit_m;
  assign blank_hours   = (state == SET_H) & ~vis;
  assign blank_minutes = (state == SET_M) & ~vis;
  assign state_dbg     = state;
endmodule

// File: tb/tb_clock_time_setter.sv
// Testbench for clock_time_setter with DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.
// Expected times come from plain modular arithmetic on the captured value
// and the number of inc presses; blink phase from elapsed cycle counts.
module tb_clock_time_setter;
  localparam int DB = 4;
  localparam int BL = 8;

  logic       clk;
  logic       resetn;
  logic       key_mode;
  logic       key_inc;
  logic [4:0] cur_h;
  logic [5:0] cur_m;
  logic       running;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic       blank_hours;
  logic       blank_minutes;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Per-cycle samples captured by the press task (index = negedge number).
  logic       run_s [32];
  logic       load_s[32];
  logic [4:0] lh_s  [32];
  logic [5:0] lm_s  [32];
  logic       bh_s  [32];
  logic       bm_s  [32];
  int         plen;

  clock_time_setter #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
    .CLOCK_50      (clk),
    .Resetn        (resetn),
    .KEY_MODE      (key_mode),
    .KEY_INC       (key_inc),
    .cur_hours     (cur_h),
    .cur_minutes   (cur_m),
    .running       (running),
    .load          (load),
    .load_hours    (load_hours),
    .load_minutes  (load_minutes),
    .blank_hours   (blank_hours),
    .blank_minutes (blank_minutes),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // Samples outputs at each negedge, then drives keys. Keys go low at
  // sample 0 and are released at sample 'hold'. A key low for edges
  // N..N+hold-1 gives a press pulse in cycle N+6 and the FSM reacts on
  // edge N+7, which shows up at sample 8.
  task automatic press(input bit m, input bit i, input int hold);
    int len;
    len = hold + 12;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      run_s[k]  = running;
      load_s[k] = load;
      lh_s[k]   = load_hours;
      lm_s[k]   = load_minutes;
      bh_s[k]   = blank_hours;
      bm_s[k]   = blank_minutes;
      if (k == 0) begin
        if (m) key_mode = 1'b0;
        if (i) key_inc  = 1'b0;
      end
      if (k == hold) begin
        key_mode = 1'b1;
        key_inc  = 1'b1;
      end
    end
    plen = len;
  endtask

  function automatic int loads_seen();
    int c;
    c = 0;
    for (int k = 0; k < plen; k++) if (load_s[k] === 1'b1) c++;
    return c;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn   = 1'b0;
    key_mode = 1'b1;
    key_inc  = 1'b1;
    cur_h    = 5'($urandom_range(0, 23));
    cur_m    = 6'($urandom_range(0, 59));
    repeat (3) @(negedge clk);
    n_vec++;
    if ({running, load, load_hours, load_minutes, blank_hours, blank_minutes} !== 15'b1_0_00000_000000_0_0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected %b",
               {running, load, load_hours, load_minutes, blank_hours, blank_minutes}, 15'b1_0_00000_000000_0_0);
    end
    n_vec++;
    if (state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_vec++;
      if ({running, load, load_hours, load_minutes, blank_hours, blank_minutes} !== 15'b1_0_00000_000000_0_0) begin
        n_err++;
        $display("FAIL post_reset_idle: cycle %0d got %b expected %b", k,
                 {running, load, load_hours, load_minutes, blank_hours, blank_minutes}, 15'b1_0_00000_000000_0_0);
      end
    end
  endtask

  // Full edit with a reference computed from clamp + count-of-presses mod N.
  task automatic run_session(input int h, input int m, input int nh, input int nm);
    int exp_h;
    int exp_m;
    cur_h = 5'(h);
    cur_m = 6'(m);
    exp_h = (h > 23) ? 0 : h;
    exp_m = (m > 59) ? 0 : m;

    press(1'b1, 1'b0, 6);
    n_vec++;
    if (run_s[7] !== 1'b1 || run_s[8] !== 1'b0) begin
      n_err++;
      $display("FAIL enter_running: got %b%b expected 10", run_s[7], run_s[8]);
    end
    n_vec++;
    if (lh_s[8] !== 5'(exp_h) || lm_s[8] !== 6'(exp_m)) begin
      n_err++;
      $display("FAIL capture: got %0d:%0d expected %0d:%0d", lh_s[8], lm_s[8], exp_h, exp_m);
    end
    // Live values move on; the edit must not follow them.
    cur_h = 5'($urandom_range(0, 31));
    cur_m = 6'($urandom_range(0, 63));

    for (int j = 0; j < nh; j++) begin
      press(1'b0, 1'b1, 6);
      exp_h = (exp_h + 1) % 24;
      n_vec++;
      if (lh_s[8] !== 5'(exp_h) || run_s[plen-1] !== 1'b0) begin
        n_err++;
        $display("FAIL inc_hours: got %0d run %b expected %0d run 0", lh_s[8], run_s[plen-1], exp_h);
      end
    end
    press(1'b1, 1'b0, 6);
    n_vec++;
    if (state_dbg !== 2'd2 || running !== 1'b0) begin
      n_err++;
      $display("FAIL to_set_m: got state %0d run %b expected state 2 run 0", state_dbg, running);
    end
    for (int j = 0; j < nm; j++) begin
      press(1'b0, 1'b1, 6);
      exp_m = (exp_m + 1) % 60;
      n_vec++;
      if (lm_s[8] !== 6'(exp_m) || lh_s[8] !== 5'(exp_h)) begin
        n_err++;
        $display("FAIL inc_minutes: got %0d:%0d expected %0d:%0d", lh_s[8], lm_s[8], exp_h, exp_m);
      end
    end
    press(1'b1, 1'b0, 6);
    n_vec++;
    if (loads_seen() != 1 || load_s[8] !== 1'b1) begin
      n_err++;
      $display("FAIL load_pulse: got %0d cycles (at 8: %b) expected 1", loads_seen(), load_s[8]);
    end
    n_vec++;
    if (lh_s[8] !== 5'(exp_h) || lm_s[8] !== 6'(exp_m)) begin
      n_err++;
      $display("FAIL load_value: got %0d:%0d expected %0d:%0d", lh_s[8], lm_s[8], exp_h, exp_m);
    end
    n_vec++;
    if (run_s[8] !== 1'b0 || run_s[9] !== 1'b1) begin
      n_err++;
      $display("FAIL run_after_load: got %b%b expected 01", run_s[8], run_s[9]);
    end
    // Inc in RUN is ignored.
    press(1'b0, 1'b1, 6);
    n_vec++;
    if (lh_s[plen-1] !== 5'(exp_h) || lm_s[plen-1] !== 6'(exp_m) || loads_seen() != 0) begin
      n_err++;
      $display("FAIL inc_in_run: got %0d:%0d loads %0d expected %0d:%0d loads 0",
               lh_s[plen-1], lm_s[plen-1], loads_seen(), exp_h, exp_m);
    end
  endtask

  task automatic test_full_edit();
    run_session(23, 59, 1, 2);
  endtask

  task automatic test_random_sessions();
    for (int s = 0; s < 6; s++)
      run_session($urandom_range(0, 31), $urandom_range(0, 63),
                  $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_debounce();
    int h0;
    h0 = $urandom_range(0, 23);
    cur_h = 5'(h0);
    cur_m = 6'($urandom_range(0, 59));
    press(1'b1, 1'b0, 6);
    for (int g = 0; g < 4; g++) begin
      @(negedge clk) key_inc = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk) key_inc = 1'b1;
      repeat (4) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    n_vec++;
    if (load_hours !== 5'(h0) || state_dbg !== 2'd1) begin
      n_err++;
      $display("FAIL glitch_rejected: got %0d state %0d expected %0d state 1", load_hours, state_dbg, h0);
    end
    press(1'b0, 1'b1, 10);
    n_vec++;
    if (lh_s[7] !== 5'(h0) || lh_s[8] !== 5'((h0 + 1) % 24)) begin
      n_err++;
      $display("FAIL press_latency: got %0d then %0d expected %0d then %0d",
               lh_s[7], lh_s[8], h0, (h0 + 1) % 24);
    end
    n_vec++;
    if (lh_s[plen-1] !== 5'((h0 + 1) % 24)) begin
      n_err++;
      $display("FAIL single_event: got %0d expected %0d", lh_s[plen-1], (h0 + 1) % 24);
    end
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
  endtask

  task automatic test_simultaneous();
    int m0;
    m0 = $urandom_range(0, 58);
    cur_h = 5'd5;
    cur_m = 6'(m0);
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b1, 6);
    n_vec++;
    if (lh_s[plen-1] !== 5'd5 || state_dbg !== 2'd2) begin
      n_err++;
      $display("FAIL both_keys: got h %0d state %0d expected h 5 state 2", lh_s[plen-1], state_dbg);
    end
    press(1'b0, 1'b1, 6);
    n_vec++;
    if (lh_s[8] !== 5'd5 || lm_s[8] !== 6'(m0 + 1)) begin
      n_err++;
      $display("FAIL both_keys_field: got %0d:%0d expected 5:%0d", lh_s[8], lm_s[8], m0 + 1);
    end
    press(1'b1, 1'b0, 6);
  endtask

  task automatic test_blink();
    int m0;
    int k;
    m0 = $urandom_range(0, 58);
    cur_h = 5'($urandom_range(0, 23));
    cur_m = 6'(m0);
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    // SET_M entered on the edge before sample 8 (k=0); last sample is k=9.
    for (int j = 0; j < 42; j++) begin
      @(negedge clk);
      k = 10 + j;
      n_vec++;
      if (blank_minutes !== 1'(((k / BL) % 2)) || blank_hours !== 1'b0) begin
        n_err++;
        $display("FAIL blink_phase: k %0d got bm %b bh %b expected bm %0d bh 0",
                 k, blank_minutes, blank_hours, (k / BL) % 2);
      end
    end
    // Press sample 0 is k=52, so sample 7 (k=59) is in a blanked phase.
    press(1'b0, 1'b1, 6);
    n_vec++;
    if (bm_s[7] !== 1'b1 || bm_s[8] !== 1'b0) begin
      n_err++;
      $display("FAIL blink_restart: got %b%b expected 10", bm_s[7], bm_s[8]);
    end
    n_vec++;
    if (lm_s[8] !== 6'(m0 + 1)) begin
      n_err++;
      $display("FAIL blink_inc: got %0d expected %0d", lm_s[8], m0 + 1);
    end
    press(1'b1, 1'b0, 6);
  endtask

  task automatic test_mid_reset();
    int loads;
    cur_h = 5'($urandom_range(0, 23));
    cur_m = 6'd30;
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    n_vec++;
    if (lm_s[plen-1] !== 6'd30 || state_dbg !== 2'd2) begin
      n_err++;
      $display("FAIL pre_reset: got m %0d state %0d expected m 30 state 2", lm_s[plen-1], state_dbg);
    end
    @(negedge clk) resetn = 1'b0;
    #1;
    n_vec++;
    if (running !== 1'b1 || load !== 1'b0 || load_minutes !== 6'd0 || state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset: got run %b load %b m %0d state %0d expected 1 0 0 0",
               running, load, load_minutes, state_dbg);
    end
    @(negedge clk) resetn = 1'b1;
    loads = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (load === 1'b1) loads++;
      n_vec++;
      if (running !== 1'b1 || load_minutes !== 6'd0 || state_dbg !== 2'd0) begin
        n_err++;
        $display("FAIL after_reset: cycle %0d got run %b m %0d state %0d expected 1 0 0",
                 k, running, load_minutes, state_dbg);
      end
    end
    n_vec++;
    if (loads != 0) begin
      n_err++;
      $display("FAIL no_load_after_reset: got %0d expected 0", loads);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_debounce();
    test_full_edit();
    test_simultaneous();
    test_blink();
    test_random_sessions();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
